// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response and program-load signals of the instruction memory
interface imem_responder_if #(parameter int DEPTH = 256);
    localparam int IDX_W = $clog2(DEPTH);
    logic read_req;
    logic [31:0] read_addr;
    logic busy;
    logic instr_valid;
    logic [31:0] instruction;
    logic addr_err;
    logic load_en;
    logic [IDX_W-1:0] load_addr;
    logic [31:0] load_data;
    modport master (
        output read_req, read_addr, load_en, load_addr, load_data,
        input busy, instr_valid, instruction, addr_err
    );
    modport slave (
        input read_req, read_addr, load_en, load_addr, load_data,
        output busy, instr_valid, instruction, addr_err
    );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch from a loadable word memory
module imem_responder #(
    parameter int DEPTH = 256,
    parameter int LATENCY = 3
) (
    input logic clk,
    input logic reset,
    imem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0] state, state_nxt;
    logic [3:0] cnt;
    logic [IDX_W-1:0] idx_q, rd_idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] instruction;
    logic addr_err, accept, bad;
    assign accept = bus.read_req && state != WAIT;
    assign bad = bus.read_addr[1:0] != 2'b0 || |bus.read_addr[31:IDX_W+2];
    // LATENCY=1 enters RESP on the accept edge, before the index is latched
    assign rd_idx = state == WAIT ? idx_q : bus.read_addr[IDX_W+1:2];
    always_comb begin
        state_nxt = state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
                  : (!accept || bad) ? IDLE
                  : LATENCY == 1 ? RESP : WAIT;
    end
    always_ff @(posedge clk) begin
        if (reset && bus.load_en) mem[bus.load_addr] <= bus.load_data;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            idx_q <= '0;
            instruction <= 32'h0;
            addr_err <= 1'b0;
        end else begin
            state <= state_nxt;
            addr_err <= accept && bad;
            cnt <= state == WAIT ? cnt - 4'd1 : state_nxt == WAIT ? 4'(LATENCY - 1) : cnt;
            if (accept) idx_q <= bus.read_addr[IDX_W+1:2];
            if (state_nxt == RESP)
                instruction <= (bus.load_en && bus.load_addr == rd_idx) ? bus.load_data : mem[rd_idx];
        end
    end
    assign bus.busy = state == WAIT;
    assign bus.instr_valid = state == RESP;
    assign bus.instruction = instruction;
    assign bus.addr_err = addr_err;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of a LATENCY=3 and a LATENCY=1 instruction responder
module tb_imem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0;
    logic [31:0] addr_a = 32'h0, addr_b = 32'h0;
    logic load_en = 1'b0;
    logic [7:0] load_addr = 8'h0;
    logic [31:0] load_data = 32'h0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    imem_responder_if #(.DEPTH(256)) a ();
    imem_responder_if #(.DEPTH(256)) b ();
    assign a.read_req = req_a;
    assign a.read_addr = addr_a;
    assign a.load_en = load_en;
    assign a.load_addr = load_addr;
    assign a.load_data = load_data;
    assign b.read_req = req_b;
    assign b.read_addr = addr_b;
    assign b.load_en = load_en;
    assign b.load_addr = load_addr;
    assign b.load_data = load_data;
    imem_responder #(.DEPTH(256), .LATENCY(3)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
    imem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_a(input string tag, input logic bsy, input logic vld, input logic err, input logic [31:0] ins);
        chk({tag, ".busy"}, 32'(a.busy), 32'(bsy));
        chk({tag, ".valid"}, 32'(a.instr_valid), 32'(vld));
        chk({tag, ".err"}, 32'(a.addr_err), 32'(err));
        chk({tag, ".instr"}, a.instruction, ins);
    endtask
    task automatic chk_b(input string tag, input logic vld, input logic err, input logic [31:0] ins);
        chk({tag, ".busy"}, 32'(b.busy), 32'(0));
        chk({tag, ".valid"}, 32'(b.instr_valid), 32'(vld));
        chk({tag, ".err"}, 32'(b.addr_err), 32'(err));
        chk({tag, ".instr"}, b.instruction, ins);
    endtask
    initial begin
        step();
        step();
        chk_a("rst_a", 0, 0, 0, 32'h0);
        chk_b("rst_b", 0, 0, 32'h0);
        reset = 1'b1;
        load_en = 1'b1;
        load_addr = 8'd0; load_data = 32'h000400FF; step();
        load_addr = 8'd1; load_data = 32'h01050603; step();
        load_addr = 8'd2; load_data = 32'hDEADBEEF; step();
        load_en = 1'b0;
        req_a = 1'b1; addr_a = 32'h0; step();
        chk_a("f0_w1", 1, 0, 0, 32'h0);
        req_a = 1'b0; step();
        chk_a("f0_w2", 1, 0, 0, 32'h0);
        step();
        chk_a("f0_resp", 0, 1, 0, 32'h000400FF);
        step();
        chk_a("f0_idle", 0, 0, 0, 32'h000400FF);
        req_a = 1'b1; addr_a = 32'h0; step();
        chk_a("bb_w1", 1, 0, 0, 32'h000400FF);
        step();
        chk_a("bb_w2", 1, 0, 0, 32'h000400FF);
        step();
        chk_a("bb_r0", 0, 1, 0, 32'h000400FF);
        addr_a = 32'h4; step();
        chk_a("bb_w3", 1, 0, 0, 32'h000400FF);
        step();
        chk_a("bb_w4", 1, 0, 0, 32'h000400FF);
        step();
        chk_a("bb_r1", 0, 1, 0, 32'h01050603);
        req_a = 1'b0; step();
        chk_a("bb_idle", 0, 0, 0, 32'h01050603);
        req_a = 1'b1; addr_a = 32'h2; step();
        chk_a("misal", 0, 0, 1, 32'h01050603);
        addr_a = 32'h400; step();
        chk_a("range", 0, 0, 1, 32'h01050603);
        req_a = 1'b0; step();
        chk_a("err_drop", 0, 0, 0, 32'h01050603);
        req_a = 1'b1; addr_a = 32'h8; step();
        req_a = 1'b0; step();
        load_en = 1'b1; load_addr = 8'd2; load_data = 32'h09040F03; step();
        load_en = 1'b0;
        chk_a("bypass", 0, 1, 0, 32'h09040F03);
        step();
        req_a = 1'b1; addr_a = 32'h4; step();
        chk_a("mid_w", 1, 0, 0, 32'h09040F03);
        req_a = 1'b0; reset = 1'b0; step();
        reset = 1'b1;
        chk_a("mid_rst", 0, 0, 0, 32'h0);
        step();
        chk_a("mid_q1", 0, 0, 0, 32'h0);
        step();
        chk_a("mid_q2", 0, 0, 0, 32'h0);
        req_a = 1'b1; addr_a = 32'h0; step();
        req_a = 1'b0; step();
        step();
        chk_a("mid_refetch", 0, 1, 0, 32'h000400FF);
        step();
        req_b = 1'b1; addr_b = 32'h0; step();
        chk_b("l1_0", 1, 0, 32'h000400FF);
        addr_b = 32'h4; step();
        chk_b("l1_4", 1, 0, 32'h01050603);
        addr_b = 32'h8; step();
        chk_b("l1_8", 1, 0, 32'h09040F03);
        addr_b = 32'h6; step();
        chk_b("l1_misal", 0, 1, 32'h09040F03);
        req_b = 1'b0; step();
        chk_b("l1_idle", 0, 0, 32'h09040F03);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction memory responder on the fetch side of the 8-bit processor.
- Accepts one byte-addressed read request at a time from the program counter and returns the 32-bit instruction word after a fixed latency, using a request/valid handshake.
- Feeds the instruction register / control unit.
- A separate load port fills memory with program words before or between fetches.

Parameters:
- DEPTH, 256, number of 32-bit words (power of two; index width IDX_W = log2(DEPTH)).
- LATENCY, 3, cycles from request accept to instr_valid (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; 0 sampled at posedge resets the block.
- read_req  in  1  fetch request, sampled when busy=0.
- read_addr  in  32  byte address of the instruction (PC value).
- busy  out  1  request in flight; read_req ignored while 1.
- instr_valid  out  1  one-cycle pulse: instruction holds the requested word.
- instruction  out  32  fetched word; holds its value between responses.
- addr_err  out  1  one-cycle pulse: last request was rejected.
- load_en  in  1  memory write strobe.
- load_addr  in  IDX_W  word index to write.
- load_data  in  32  word to write.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE; busy=0, instr_valid=0, addr_err=0, instruction=32'h0, latency counter=0.
  - Memory contents are NOT cleared.
  - load_en is ignored in that cycle.
  - Reset in WAIT abandons the request; no instr_valid is produced.
- States IDLE, WAIT, RESP. busy = (state==WAIT).
- Accept: read_req=1 at posedge k in IDLE or RESP. Word index = read_addr[IDX_W+1:2], latched.
- Reject: read_addr[1:0]!=0, or read_addr >= DEPTH*4.
  - addr_err=1 for the cycle after edge k; state -> IDLE.
  - No busy, no instr_valid.
- Good request with LATENCY=1: -> RESP at edge k; instr_valid=1 during the cycle after edge k.
- Good request with LATENCY>1: -> WAIT at edge k, counter=LATENCY-1. Counter decrements each WAIT cycle; at counter==1 the next edge goes -> RESP.
  - instr_valid is high exactly in the cycle after edge k+LATENCY-1. The response is LATENCY cycles after the request cycle.
- Memory read happens on the edge entering RESP.
  - If load_en=1 on that same edge with load_addr == latched index, instruction = load_data (write-through bypass).
  - Loads to the word earlier in WAIT are also visible.
- RESP lasts one cycle. instr_valid drops afterwards unless a new accepted request with LATENCY=1 re-enters RESP.
- RESP -> WAIT or IDLE/RESP per the accept rules if read_req=1 in RESP; otherwise -> IDLE. Back-to-back fetches therefore sustain one word per LATENCY cycles.
- read_req in WAIT is dropped (no queue); the requester must hold or re-issue it.
- Loads are accepted in any state when reset=1, one word per cycle. The write completes at the posedge.
- instruction changes only on the edge entering RESP (and at reset).
- Address arithmetic: read_addr is treated as unsigned. No wrap: out-of-range addresses always reject.

Test Plan:
- Reset then load sequence:
  - Stimulus: reset=0 for 2 cycles; load word0=32'h000400FF (loadi 4,X,0xFF), word1=32'h01050603 (add 5,6,3); read_req with addr 0.
  - Response: busy=1 for 2 cycles; instr_valid pulses 3 cycles after accept with instruction=32'h000400FF; busy=0, addr_err=0 throughout.
- Back-to-back fetch:
  - Stimulus: read_req held high, addr 0 then 4 (PC +4 on each instr_valid).
  - Response: valid pulses 3 cycles apart; instruction 32'h000400FF then 32'h01050603; requests during WAIT have no effect.
- Misaligned and out-of-range:
  - Stimulus: addr 32'h2, then 32'h400 (DEPTH=256).
  - Response: addr_err one-cycle pulse each; busy and instr_valid stay 0; instruction unchanged.
- Bypass:
  - Stimulus: fetch addr 8; on the RESP-entry edge drive load_en with load_addr=2, load_data=32'h09040F03.
  - Response: instruction=32'h09040F03.
- Reset mid-operation:
  - Stimulus: accept a fetch, drop reset for 1 cycle during WAIT.
  - Response: busy=0, instruction=0, no instr_valid; memory still holds 32'h000400FF at word0 on the next fetch.
- LATENCY=1 instance:
  - Stimulus: read_req every cycle, addresses 0, 4, 8.
  - Response: instr_valid high every cycle after the first accept; busy never asserts.
